// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core (A) has zero-wait priority, secondary master (B) gets req/gnt
// with a starvation escape and capped locked bursts. Define DMEM_ARB_RR_EN for round-robin A_OWN.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wd,
  output logic          a_gnt,
  output logic [DW-1:0] a_rd,
  input  logic          b_req,
  input  logic          b_lock,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wd,
  output logic          b_gnt,
  output logic [DW-1:0] b_rd,
  output logic          b_rvalid,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd
);

  localparam int            CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_MAX   = CW'(STARVE_MAX);
  // A one-cycle burst cap means the granting cycle is already the whole burst.
  localparam bit            LOCK_OK = (STARVE_MAX > 1);

  typedef enum logic [1:0] {
    A_OWN   = 2'd0,
    FORCE_B = 2'd1,
    B_OWN   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_starve_cnt;
  logic [CW-1:0] w_starve_nxt;
  logic [CW-1:0] r_burst_cnt;
  logic [CW-1:0] w_burst_nxt;
  logic [CW-1:0] w_burst_inc;
  logic          w_a_gnt;
  logic          w_b_gnt;
  logic          w_a_first;
  logic          w_b_read;
  logic [DW-1:0] r_b_rd;
  logic          r_b_rvalid;

`ifdef DMEM_ARB_RR_EN
  logic          r_last_b;

  // When both contend in A_OWN, the port that did not win last time goes first.
  assign w_a_first = r_last_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (w_a_gnt) begin
      r_last_b <= 1'b0;
    end else if (w_b_gnt) begin
      r_last_b <= 1'b1;
    end
  end
`else
  localparam logic [CW-1:0] C_MAX_M1 = CW'(STARVE_MAX - 1);

  assign w_a_first = 1'b1;
`endif

  assign w_burst_inc = r_burst_cnt + C_ONE;

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_a_gnt      = 1'b0;
    w_b_gnt      = 1'b0;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_burst_nxt  = r_burst_cnt;
    if (rst_n) begin
      case (r_state)
        A_OWN: begin
          w_a_gnt     = a_req & (w_a_first | ~b_req);
          w_b_gnt     = b_req & ~w_a_gnt;
          w_burst_nxt = '0;
          if (w_b_gnt) begin
            w_starve_nxt = '0;
            if (b_lock && LOCK_OK) begin
              w_state_nxt = B_OWN;
              w_burst_nxt = C_ONE;
            end
          end else if (b_req) begin
`ifndef DMEM_ARB_RR_EN
            if (r_starve_cnt == C_MAX_M1) begin
              w_state_nxt = FORCE_B;
            end
            if (r_starve_cnt != C_MAX) begin
              w_starve_nxt = r_starve_cnt + C_ONE;
            end
`endif
          end
        end

        FORCE_B: begin
          w_state_nxt  = A_OWN;
          w_starve_nxt = '0;
          w_burst_nxt  = '0;
          if (b_req) begin
            w_b_gnt = 1'b1;
            if (b_lock && LOCK_OK) begin
              w_state_nxt = B_OWN;
              w_burst_nxt = C_ONE;
            end
          end else begin
            w_a_gnt = a_req;
          end
        end

        B_OWN: begin
          w_state_nxt  = A_OWN;
          w_starve_nxt = '0;
          w_burst_nxt  = '0;
          if (b_req) begin
            w_b_gnt = 1'b1;
            // The cap counts the entry grant, so a burst is at most STARVE_MAX B cycles.
            if (b_lock && (w_burst_inc < C_MAX)) begin
              w_state_nxt = B_OWN;
              w_burst_nxt = w_burst_inc;
            end
          end else begin
            w_a_gnt = a_req;
          end
        end

        default: begin
          w_state_nxt  = A_OWN;
          w_starve_nxt = '0;
          w_burst_nxt  = '0;
        end
      endcase
    end
  end

  assign w_b_read = w_b_gnt & ~b_we;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= A_OWN;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
      r_b_rd       <= '0;
      r_b_rvalid   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_b_rvalid   <= w_b_read;
      if (w_b_read) begin
        r_b_rd <= m_rd;
      end
    end
  end

  // Idle memory cycles present the core address so a_rd tracks it without waiting for a grant.
  assign m_we     = (w_a_gnt & a_we) | (w_b_gnt & b_we);
  assign m_addr   = w_b_gnt ? b_addr : a_addr;
  assign m_wd     = w_b_gnt ? b_wd : a_wd;
  assign a_rd     = m_rd;
  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign b_rd     = r_b_rd;
  assign b_rvalid = r_b_rvalid;

  a_grants_exclusive: assert property (@(posedge clk) !(a_gnt && b_gnt));
  a_no_write_in_reset: assert property (@(posedge clk) !rst_n |-> !m_we);

endmodule
